// File: rtl/fetch_pkg.sv
// Shared constants, entry type and helpers for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned FETCH_DEPTH = 2;
  localparam int unsigned XLEN        = 32;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Saturating add of a small increment to a 32-bit event counter.
  function automatic logic [31:0] sat_add32(logic [31:0] a, logic [1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry shifting queue of fetched {instr, pc}; entry 0 is always the head.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned width = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [width-1:0] head,
  output logic [1:0]       count
);

  logic [width-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]       count_q, count_d;

  assign head  = e0_q;
  assign count = count_q;

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    // Flush wins over push; stored data is left in place so the head holds.
    if (flush) begin
      count_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) e0_d = push_data;
          else                 e1_d = push_data;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          e0_d    = e1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            e0_d = push_data;
          end else begin
            e0_d = e1_q;
            e1_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= '0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

`ifndef SYNTHESIS
  // Issue credit guarantees space; a push into a full queue is a design bug.
  no_overrun: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && count_q == 2'(FETCH_DEPTH)));
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, imem request credit, redirect/flush and a 2-entry output queue.
// Define FETCH_PERF_EN to add saturating perf_fetched/perf_flushed counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned               address_width = 32,
  parameter int unsigned               data_width    = 32,
  parameter logic [address_width-1:0]  RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [address_width-1:0] imem_addr,
  input  logic [data_width-1:0]    imem_rdata,
  input  logic                     PCsrc,
  input  logic [address_width-1:0] branch_pc,
  input  logic [address_width-1:0] ImmOp,
  output logic [data_width-1:0]    instr,
  output logic [address_width-1:0] instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_flushed
`endif
);

  localparam int unsigned EntryW = data_width + address_width;

  logic [address_width-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
  logic [address_width-1:0] target_sum, target;
  logic                     inflight_q, inflight_d, drop_q, drop_d;
  logic                     push, pop;
  logic [1:0]               count;
  logic [2:0]               credit;
  logic [EntryW-1:0]        head;

  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid & instr_ready;
  // Occupancy after this cycle, counting the response still on its way back.
  assign credit      = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
  assign imem_req    = !rst && !PCsrc && (credit < 3'(FETCH_DEPTH));
  assign imem_addr   = pc_q;
  assign push        = inflight_q & !drop_q & !PCsrc;

  assign target_sum  = branch_pc + ImmOp;
  assign target      = {target_sum[address_width-1:2], 2'b00};

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    drop_d        = 1'b0;
    if (PCsrc) begin
      pc_d   = target;
      drop_d = inflight_q;
    end else if (imem_req) begin
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      pc_d          = pc_q + address_width'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      drop_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(
    .width(EntryW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data({imem_rdata, inflight_pc_q}),
    .pop      (pop),
    .flush    (PCsrc),
    .head     (head),
    .count    (count)
  );

  assign instr    = head[EntryW-1:address_width];
  assign instr_pc = head[address_width-1:0];

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, flushed_q;
  logic [1:0]  flush_n;

  // Entries lost at a redirect: queued-but-unpopped plus a live response.
  assign flush_n = (count - {1'b0, pop}) + {1'b0, inflight_q & !drop_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      if (push)  fetched_q <= sat_add32(fetched_q, 2'd1);
      if (PCsrc) flushed_q <= sat_add32(flushed_q, flush_n);
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PC stream queued by stimulus, checked on each pop.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] XOR_KEY  = 32'hA5A5_0000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        PCsrc = 1'b0;
  logic [31:0] branch_pc = '0;
  logic [31:0] ImmOp = '0;
  logic [31:0] instr, instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b1;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_instr_pc;
  logic [31:0] w_rdata = '0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed, w_perf_fetched, w_perf_flushed;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .PCsrc      (PCsrc),
    .branch_pc  (branch_pc),
    .ImmOp      (ImmOp),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed)
`endif
  );

  // Second instance exercises PC wrap-around.
  fetch_unit #(
    .RESET_PC(WRAP_PC)
  ) dut_wrap (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (w_req),
    .imem_addr  (w_addr),
    .imem_rdata (w_rdata),
    .PCsrc      (1'b0),
    .branch_pc  (32'h0),
    .ImmOp      (32'h0),
    .instr      (w_instr),
    .instr_pc   (w_instr_pc),
    .instr_valid(w_valid),
    .instr_ready(1'b1)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(w_perf_fetched),
    .perf_flushed(w_perf_flushed)
`endif
  );

  // Synchronous instruction memory: data = address ^ key, one cycle after the request.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr ^ XOR_KEY;
    if (w_req)    w_rdata    <= w_addr ^ XOR_KEY;
  end

  int           n_vec = 0;
  int           n_err = 0;
  fetch_entry_t exp_q[$];
  logic [31:0]  next_pc;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: consumed stream is sequential from the last reset/redirect target.
  task automatic top_up();
    fetch_entry_t e;
    while (exp_q.size() < 8) begin
      e.pc    = next_pc;
      e.instr = next_pc ^ XOR_KEY;
      exp_q.push_back(e);
      next_pc += 32'd4;
    end
  endtask

  task automatic restart(logic [31:0] start);
    exp_q.delete();
    next_pc = start;
    top_up();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    top_up();
  endtask

  // Monitor: every accepted head entry is compared with the model's next entry.
  fetch_entry_t mon_e;
  int           idle = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        idle = 0;
      end else if (instr_valid && instr_ready) begin
        idle = 0;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pop: got pc %h, expected no entry", instr_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("head_pc", instr_pc, mon_e.pc);
          check("head_instr", instr, mon_e.instr);
        end
      end else if (instr_ready) begin
        idle++;
        if (idle == 20) check("watchdog_valid", 32'(instr_valid), 32'd1);
      end
    end
  end

  logic        redir, prev_redir;
  logic [31:0] tgt;
  int          off;
  logic [4:0]  exp_req_seq, exp_vld_seq;

  initial begin
    restart(32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_wrap_addr", w_addr, WRAP_PC);

    // Reset release, ready held high: requests on consecutive cycles, valid on cycle 2.
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("seq_req", 32'(imem_req), 32'd1);
      check("seq_addr", imem_addr, 32'(c * 4));
      check("seq_valid", 32'(instr_valid), (c == 2) ? 32'd1 : 32'd0);
      check("wrap_addr", w_addr, WRAP_PC + 32'(c * 4));
    end
    check("first_pc", instr_pc, 32'h0);
    repeat (6) tick();

    // Stall until the queue fills, then reset mid-stream.
    instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("full_req", 32'(imem_req), 32'd0);
    check("full_valid", 32'(instr_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_valid", 32'(instr_valid), 32'd0);
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_addr", imem_addr, 32'h0);
    check("midrst_instr_pc", instr_pc, 32'h0);
`ifdef FETCH_PERF_EN
    check("midrst_perf_fetched", perf_fetched, 32'd0);
    check("midrst_perf_flushed", perf_flushed, 32'd0);
`endif
    restart(32'h0);

    // Restart with ready low for 5 cycles: credit stops issue at two entries.
    @(posedge clk);
    #1 rst = 1'b0;
    exp_req_seq = 5'b00011;
    exp_vld_seq = 5'b11100;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_req", 32'(imem_req), 32'(exp_req_seq[c]));
      check("bp_valid", 32'(instr_valid), 32'(exp_vld_seq[c]));
    end
    tick();
    instr_ready = 1'b1;
    repeat (6) tick();

    // Redirect to 0x10 - 8 = 0x8.
    PCsrc     = 1'b1;
    branch_pc = 32'h10;
    ImmOp     = 32'hFFFF_FFF8;
    @(negedge clk);
    check("redir_req", 32'(imem_req), 32'd0);
    tick();
    PCsrc = 1'b0;
    restart(32'h8);
    @(negedge clk);
    check("redir_addr", imem_addr, 32'h8);
    check("redir_req_next", 32'(imem_req), 32'd1);
    check("redir_flush_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check("redir_valid_r2", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check("redir_valid_r3", 32'(instr_valid), 32'd1);
    check("redir_pc_r3", instr_pc, 32'h8);

    // Misaligned target 0x20 + 6 is forced to 0x24.
    tick();
    PCsrc     = 1'b1;
    branch_pc = 32'h20;
    ImmOp     = 32'h6;
    tick();
    PCsrc = 1'b0;
    restart(32'h24);
    @(negedge clk);
    check("misalign_addr", imem_addr, 32'h24);

    // Random ready backpressure and redirects against the stream model.
    prev_redir = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (prev_redir) restart(tgt);
      instr_ready = ($urandom_range(0, 9) < 7);
      redir       = !prev_redir && ($urandom_range(0, 19) == 0);
      branch_pc   = $urandom();
      if ($urandom_range(0, 1) == 1) begin
        ImmOp = $urandom();
      end else begin
        off   = int'($urandom_range(0, 255)) - 128;
        ImmOp = 32'(off);
      end
      PCsrc      = redir;
      tgt        = (branch_pc + ImmOp) & 32'hFFFF_FFFC;
      prev_redir = redir;
    end
    tick();
    if (prev_redir) restart(tgt);
    PCsrc       = 1'b0;
    instr_ready = 1'b1;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
